// File: rtl/prog_timer.sv
// prog_timer: multi-channel programmable timer / tick generator on the IO bus.
//
// Each channel has a prescaler, a down-counter with reload, one-shot or
// periodic mode, a square-wave output and a sticky expiry flag. Downstream
// logic should use tick_o as a clock enable rather than derive a clock from it.
//
// Ports:
//   clk     system clock
//   rst     synchronous reset, active-high
//   ce      bus access strobe
//   we      write enable (a write happens only when ce=1 and we=1)
//   addr    byte address: [7:4] channel, [3:2] register, [1:0] ignored
//   data_i  write data
//   data_o  read data, combinational from addr while ce=1, else 0
//   tick_o  per-channel one-cycle expiry pulse (registered)
//   wave_o  per-channel square wave, toggles on expiry when wave_en=1
//   irq_o   OR over channels of (expired & irq_en)
//
// Register map per channel:
//   0 CTRL   bit0 en, bit1 periodic, bit2 irq_en, bit3 wave_en,
//            bits[16+PRESC_W-1:16] PRESC
//   1 LOAD   reload value
//   2 COUNT  current count (read-only)
//   3 STATUS bit0 expired (sticky, write 1 to clear)
module prog_timer #(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              we,
  input  logic [7:0]        addr,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] wave_o,
  output logic              irq_o
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic        wr;
  logic [3:0]  sel_ch;
  logic [1:0]  sel_reg;
  logic        bus_unused;

  assign wr      = ce & we;
  assign sel_ch  = addr[7:4];
  assign sel_reg = addr[3:2];
  // Byte-lane bits and reserved data bits carry no meaning here.
  assign bus_unused = ^{addr[1:0], data_i};

  logic [31:0]       rd_word [NUM_CH];
  logic [NUM_CH-1:0] irq_vec;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
    logic               en_reg, periodic_reg, irq_en_reg, wave_en_reg;
    logic               expired_reg, tick_reg, wave_reg;
    logic [PRESC_W-1:0] presc_reg, pcnt_reg;
    logic [CNT_W-1:0]   load_reg, count_reg, load_next;
    logic               hit, wr_ctrl, wr_load, wr_stat;
    logic               kill, pstep, expire;
    logic [31:0]        ctrl_word;

    assign hit     = wr && (sel_ch == 4'(gi));
    assign wr_ctrl = hit && (sel_reg == REG_CTRL);
    assign wr_load = hit && (sel_reg == REG_LOAD);
    assign wr_stat = hit && (sel_reg == REG_STATUS);

    // A CTRL write clearing en pre-empts anything the counter would do this cycle.
    assign kill   = wr_ctrl && !data_i[0];
    // >= rather than == so that shrinking PRESC below the running prescaler
    // value still produces a step instead of a long wrap-around.
    assign pstep  = en_reg && !kill && (pcnt_reg >= presc_reg);
    assign expire = pstep && (count_reg == '0);
    // A LOAD write coinciding with a reload is picked up by that reload.
    assign load_next = wr_load ? data_i[CNT_W-1:0] : load_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        en_reg       <= 1'b0;
        periodic_reg <= 1'b0;
        irq_en_reg   <= 1'b0;
        wave_en_reg  <= 1'b0;
        expired_reg  <= 1'b0;
        tick_reg     <= 1'b0;
        wave_reg     <= 1'b0;
        presc_reg    <= '0;
        pcnt_reg     <= '0;
        load_reg     <= '0;
        count_reg    <= '0;
      end else begin
        tick_reg <= 1'b0;

        if (wr_load)
          load_reg <= data_i[CNT_W-1:0];

        // Placed before the expiry update so a coincident expiry wins.
        if (wr_stat && data_i[0])
          expired_reg <= 1'b0;

        if (wr_ctrl) begin
          en_reg       <= data_i[0];
          periodic_reg <= data_i[1];
          irq_en_reg   <= data_i[2];
          wave_en_reg  <= data_i[3];
          presc_reg    <= data_i[16 +: PRESC_W];
          if (data_i[0] && !en_reg) begin
            count_reg <= load_next;
            pcnt_reg  <= '0;
          end
        end

        if (en_reg && !kill) begin
          if (!pstep) begin
            pcnt_reg <= pcnt_reg + PRESC_W'(1);
          end else begin
            pcnt_reg <= '0;
            if (!expire) begin
              count_reg <= count_reg - CNT_W'(1);
            end else begin
              expired_reg <= 1'b1;
              tick_reg    <= 1'b1;
              if (wave_en_reg)
                wave_reg <= ~wave_reg;
              if (periodic_reg)
                count_reg <= load_next;
              else
                en_reg <= 1'b0;   // one-shot: stop, count stays at 0
            end
          end
        end
      end
    end

    assign ctrl_word = (32'(presc_reg) << 16) |
                       {28'd0, wave_en_reg, irq_en_reg, periodic_reg, en_reg};

    assign rd_word[gi] = (sel_reg == REG_CTRL)  ? ctrl_word :
                         (sel_reg == REG_LOAD)  ? 32'(load_reg) :
                         (sel_reg == REG_COUNT) ? 32'(count_reg) :
                                                  {31'd0, expired_reg};

    assign tick_o[gi]  = tick_reg;
    assign wave_o[gi]  = wave_reg;
    assign irq_vec[gi] = expired_reg & irq_en_reg;
  end

  assign irq_o = |irq_vec;

  // Channels beyond NUM_CH fall through and read as 0.
  always_comb begin
    data_o = '0;
    if (ce) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel_ch == 4'(i))
          data_o = rd_word[i];
      end
    end
  end

endmodule
